// File: rtl/ones_expander.sv
// Sequential count-to-pattern decoder: turns a count into a word holding that many contiguous ones, one bit per clock.
// Optional build macro ONES_EXPANDER_MSB_FIRST_EN fills from bit 7 downward instead of from bit 0 upward.
module ones_expander #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] n,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             ovf_reg, ovf_next;
  logic [CNT_W-1:0] n_eff;
  logic             n_over;
  logic [WIDTH-1:0] fill_word;

  // Saturating clamp: anything above WIDTH still builds a full word, never wraps.
  assign n_over = (n > WIDTH_CNT);
  assign n_eff  = n_over ? WIDTH_CNT : n;

`ifdef ONES_EXPANDER_MSB_FIRST_EN
  assign fill_word = {1'b1, q_reg[WIDTH-1:1]};
`else
  assign fill_word = {q_reg[WIDTH-2:0], 1'b1};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      q_reg     <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      q_reg     <= q_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    q_next     = q_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (load) begin
          q_next   = '0;
          ovf_next = n_over;
          if (n_eff == '0) begin
            state_next = DONE;
          end else begin
            rem_next   = n_eff;
            state_next = FILL;
          end
        end else begin
          state_next = IDLE;
        end
      end
      FILL: begin
        // load is deliberately ignored here; there is no request queue.
        q_next   = fill_word;
        rem_next = rem_reg - 1'b1;
        if (rem_reg == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_reg == FILL);
    done = (state_reg == DONE);
    q    = q_reg;
    ovf  = ovf_reg;
  end

endmodule

// File: tb/tb_ones_expander.sv
// Directed self-checking bench for ones_expander; expected patterns follow the build's fill direction.
module tb_ones_expander;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] n;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  ones_expander #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .n     (n),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
    end else begin
      $display("ok   %s value=%0h", tag, observed);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pattern after k fill steps; hand values: default 01,03,07..FF, msb-first 80,C0,E0..FF.
  function automatic logic [7:0] pat(input int k);
`ifdef ONES_EXPANDER_MSB_FIRST_EN
    logic [7:0] tbl [0:8] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
`else
    logic [7:0] tbl [0:8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
`endif
    return tbl[k];
  endfunction

  // Issues a load, walks the fill cycles and stops in the DONE cycle.
  task automatic run_job(input logic [3:0] cnt, input int neff, input logic exp_ovf, input logic [7:0] exp_q);
    load = 1'b1;
    n    = cnt;
    tick();
    load = 1'b0;
    for (int i = 0; i < neff; i++) begin
      check($sformatf("n%0d_fill%0d_busy", cnt, i), 32'(busy), 32'd1);
      check($sformatf("n%0d_fill%0d_q", cnt, i), 32'(q), 32'(pat(i)));
      check($sformatf("n%0d_fill%0d_done", cnt, i), 32'(done), 32'd0);
      check($sformatf("n%0d_fill%0d_ovf", cnt, i), 32'(ovf), 32'(exp_ovf));
      tick();
    end
    check($sformatf("n%0d_done", cnt), 32'(done), 32'd1);
    check($sformatf("n%0d_done_busy", cnt), 32'(busy), 32'd0);
    check($sformatf("n%0d_final_q", cnt), 32'(q), 32'(exp_q));
    check($sformatf("n%0d_ovf", cnt), 32'(ovf), 32'(exp_ovf));
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b1;
    n     = 4'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst%0d_q", i), 32'(q), 32'h00);
      check($sformatf("rst%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("rst%0d_done", i), 32'(done), 32'd0);
      check($sformatf("rst%0d_ovf", i), 32'(ovf), 32'd0);
    end
    load  = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

`ifdef ONES_EXPANDER_MSB_FIRST_EN
    run_job(4'd3, 3, 1'b0, 8'hE0);
`else
    run_job(4'd3, 3, 1'b0, 8'h07);
`endif
    tick();
    check("n3_after_done", 32'(done), 32'd0);
`ifdef ONES_EXPANDER_MSB_FIRST_EN
    check("n3_q_hold", 32'(q), 32'hE0);
`else
    check("n3_q_hold", 32'(q), 32'h07);
`endif

    run_job(4'd0, 0, 1'b0, 8'h00);
    tick();
    run_job(4'd8, 8, 1'b0, 8'hFF);
    tick();
    run_job(4'd12, 8, 1'b1, 8'hFF);
    tick();
    check("ovf_hold_idle", 32'(ovf), 32'd1);
`ifdef ONES_EXPANDER_MSB_FIRST_EN
    run_job(4'd2, 2, 1'b0, 8'hC0);
`else
    run_job(4'd2, 2, 1'b0, 8'h03);
`endif
    tick();
    run_job(4'd15, 8, 1'b1, 8'hFF);
    tick();

    // Load n=4, pulse n=1 mid-fill; the pulse must be ignored.
    load = 1'b1;
    n    = 4'd4;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1;
    n    = 4'd1;
    tick();
    load = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_q", 32'(q), 32'(pat(2)));
    tick();
    tick();
    check("ign_done", 32'(done), 32'd1);
    check("ign_final_q", 32'(q), 32'(pat(4)));

    // Back-to-back: load held during the DONE cycle is accepted.
    run_job(4'd1, 1, 1'b0, pat(1));
    tick();

    // Reset mid-fill aborts with no done.
    load = 1'b1;
    n    = 4'd6;
    tick();
    load = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_q", 32'(q), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("abort_nodone%0d", i), 32'(done), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ones_expander.md
# ones_expander

Sequential count-to-pattern decoder, the inverse of the bit-counting datapath. It accepts a 4-bit count on `load` and builds an 8-bit word containing exactly that many ones, inserting one bit per clock. Its finished word fed back through the bit counter must reproduce the original count (saturated). It sits between the count-producing logic and any consumer that needs a thermometer-style mask.

## Interface
- `WIDTH`, 8: output word width. Fixed at 8 for this release.
- `CNT_W`, 4: count input width. Must satisfy 2^CNT_W > WIDTH.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low. Sampled on the `clk` rising edge.
- `load` input 1: start request. Accepted only when `busy`=0.
- `n` input 4: requested number of ones. Sampled on the accepting edge.
- `q` output 8 (reg): pattern under construction or finished.
- `busy` output 1: high while filling.
- `done` output 1: single-cycle completion strobe. `q` is final while it is high.
- `ovf` output 1: set when the accepted `n` exceeded `WIDTH`. Valid from acceptance until the next acceptance.

## Operation
- States: IDLE, FILL, DONE. The state register and a `rem` counter (CNT_W bits) are internal.
- `n_eff` = min(`n`, WIDTH). Saturating compare; no wrap.
- IDLE or DONE with `load`=1 (acceptance):
  - `q` is cleared to 0.
  - `ovf` is set to (`n` > WIDTH).
  - If `n_eff`=0, go to DONE.
  - Otherwise set `rem` = `n_eff` and go to FILL.
- IDLE or DONE with `load`=0: go to IDLE. `q` and `ovf` hold.
- FILL, each cycle:
  - Shift `q` left and insert a 1 at bit 0, i.e. `q` = {`q`[6:0],1}. The MSB-first variant is under Configuration.
  - `rem` decrements.
  - When `rem` goes 1 to 0, go to DONE.
- FILL ignores `load`. There is no queueing and no error for a `load` ignored during FILL.
- `busy` is high exactly in FILL.
- `done` is high exactly in DONE.
- Invariant: in DONE, popcount(`q`) = `n_eff` and the ones are contiguous from the fill end.
- Back-to-back: a `load` during DONE is accepted. Completion of the previous job is still signalled because `done` is high that cycle.

## Timing
- Reset, with `rst_n`=0 at an edge: state=IDLE, `q`=8'h00, `busy`=0, `done`=0, `ovf`=0, `rem`=0.
- Reset wins over `load` at the same edge.
- Reset mid-FILL aborts the job. No `done` is produced.
- Acceptance edge k:
  - `done` is high in the cycle after edge k+`n_eff`.
  - Latency from `load` to `done` is therefore `n_eff`+1 cycles, with 1 cycle for `n`=0.
- `busy` is high in the cycles after edges k through k+`n_eff`-1. It never rises for `n_eff`=0.
- After filling, `q` holds its value indefinitely until the next acceptance or reset.
- Maximum job length is 8 FILL cycles, even for `n`=15.

## Configuration
- Macro: `ONES_EXPANDER_MSB_FIRST_EN`.
- Defined: ones enter at bit 7 and shift right, i.e. `q` = {1,`q`[7:1]}. `n`=3 yields 8'hE0.
- Undefined (default): ones enter at bit 0 and shift left. `n`=3 yields 8'h07.
- Latency, handshake and `ovf` are identical in both builds.

## Test plan
- Reset with `rst_n`=0 for 2 cycles and `load`=1, `n`=5 driven → `q`=00, `busy`=0, `done`=0, `ovf`=0 throughout.
- `load` with `n`=3 (default build) → `q` steps through 01, 03, 07; `busy` high 3 cycles; `done` high 1 cycle with `q`=07; `ovf`=0.
- `load` with `n`=0 → `busy` never rises; `done` the next cycle with `q`=00. Then `load` with `n`=8 → `q`=FF at `done` after 8 FILL cycles.
- `load` with `n`=12 → `ovf`=1, 8 FILL cycles, `q`=FF. Then `load` with `n`=2 → `ovf`=0, `q`=03.
- Ignored and back-to-back loads:
  - `load` with `n`=4, then `load` with `n`=1 pulsed mid-FILL → ignored; `done` with `q`=0F.
  - `load` with `n`=1 held during the DONE cycle → accepted; next `done` with `q`=01.
  - `rst_n`=0 mid-FILL of `n`=6 → `q`=00 next cycle; no `done`.
- `ONES_EXPANDER_MSB_FIRST_EN` build, `load` with `n`=3 → `q` steps 80, C0, E0; `done` timing identical to the default build.
